// File: rtl/ex_mul_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply sequencer.
// Holds the ALUctr opcode values seen in the DX register and the
// sequencer FSM state encoding.
package ex_mul_sequencer_pkg;

    // ALU control values carried in the DX register
    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_SLT    = 3'd4,
        ALU_MUL    = 3'd5,
        ALU_BRANCH = 3'd6
    } alu_op_e;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_sequencer_if.sv
// Pipeline-side bundle between the DX/EX registers and the multiply sequencer.
// master: the pipeline (drives issue info and flush, receives stall/result).
// slave : the sequencer.
//   dx_valid, ALUctr, A, B, DX_RD, flush : issue side
//   stall, busy, mul_done, mul_result, mul_rd : sequencer response
interface ex_mul_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             dx_valid;
    logic [2:0]       ALUctr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       DX_RD;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic [4:0]       mul_rd;

    modport master (
        output dx_valid, ALUctr, A, B, DX_RD, flush,
        input  stall, busy, mul_done, mul_result, mul_rd
    );

    modport slave (
        input  dx_valid, ALUctr, A, B, DX_RD, flush,
        output stall, busy, mul_done, mul_result, mul_rd
    );
endinterface

// File: rtl/ex_mul_sequencer_mul_shift_add_step.sv
// One iteration of the shift-add multiply (mul_shift_add_step), purely combinational.
//   acc, mcand, mplier                 : current partial product, multiplicand, multiplier
//   acc_next, mcand_next, mplier_next  : values after this iteration
//   zero_flag                          : shifted multiplier has no bits left
module ex_mul_sequencer_mul_shift_add_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next,
    output logic             zero_flag
);

    // Add the multiplicand when the current multiplier bit is set; carry out is dropped
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        zero_flag   = (mplier_next == '0);
    end

endmodule

// File: rtl/ex_mul_sequencer.sv
// Multi-cycle multiply controller for the EX stage.
// Latches A/B/DX_RD on a multiply issue, iterates a shift-add multiply and
// keeps IF/ID/DX stalled until the low WIDTH bits of the product are handed
// to EX/MEM with a one-cycle mul_done strobe.
//   clk  : pipeline clock
//   rst  : synchronous, active-low reset
//   bus  : ex_mul_sequencer_if.slave (issue inputs, flush, stall/busy/result outputs)
module ex_mul_sequencer
    import ex_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter logic [2:0]  MUL_OP     = 3'd5
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_mul_sequencer_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mul_state_e       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;

    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] mcand_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic             mplier_zero;
    logic             start_c;
    logic             last_step_c;

    ex_mul_sequencer_mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_nx),
        .mcand_next  (mcand_nx),
        .mplier_next (mplier_nx),
        .zero_flag   (mplier_zero)
    );

    // Issue qualifier; gated by reset so nothing stalls while the block is held in reset
    assign start_c     = rst && bus.dx_valid && (bus.ALUctr == MUL_OP) && !bus.flush;
    assign last_step_c = (cnt == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && mplier_zero);

    // Stall covers the issue cycle too, so DX keeps the mul until the result is handed over
    assign bus.stall = rst && ((state == ST_BUSY) || start_c);
    assign bus.busy  = (state == ST_BUSY);

    // FSM, datapath registers and registered result strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            cnt            <= '0;
            rd_q           <= '0;
            bus.mul_done   <= 1'b0;
            bus.mul_result <= '0;
            bus.mul_rd     <= '0;
        end else begin
            bus.mul_done   <= 1'b0;
            bus.mul_result <= '0;
            bus.mul_rd     <= '0;
            case (state)
                // DONE accepts a new issue directly so back-to-back muls have no idle gap
                ST_IDLE, ST_DONE: begin
                    if (start_c) begin
                        acc    <= '0;
                        mcand  <= bus.A;
                        mplier <= bus.B;
                        cnt    <= '0;
                        rd_q   <= bus.DX_RD;
                        state  <= ST_BUSY;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc    <= acc_nx;
                        mcand  <= mcand_nx;
                        mplier <= mplier_nx;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_step_c) begin
                            state          <= ST_DONE;
                            bus.mul_done   <= 1'b1;
                            bus.mul_result <= acc_nx;
                            bus.mul_rd     <= rd_q;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_mul_sequencer.md
Name: ex_mul_sequencer

Overview:
- Multi-cycle controller for the multiply operation (ALUctr = 3'd5) in the EX stage.
- On a multiply issue it latches A/B/RD and runs an iterative shift-add multiply.
- It holds the IF/ID/DX pipeline registers stalled until the product is ready, then hands the low 32-bit product and destination register to the EX/MEM register for one cycle.
- Replaces the single-cycle A*B path, which limits timing.

Parameters:
- WIDTH, 32, operand/result width in bits.
- EARLY_EXIT, 1, when 1 the multiply finishes as soon as the remaining multiplier bits are all zero.
- MUL_OP, 3'd5, ALUctr encoding that identifies a multiply.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low: state is reset on a rising clk edge while rst is 0.
- dx_valid  input  1  DX register holds a real, non-bubble instruction.
- ALUctr  input  3  ALU control from DX register.
- A  input  WIDTH  multiplicand operand.
- B  input  WIDTH  multiplier operand.
- DX_RD  input  5  destination register of the issuing instruction.
- flush  input  1  branch/jal squash; abandons any multiply in flight.
- stall  output  1  freeze IF, ID and DX registers; EX/MEM captures a bubble.
- busy  output  1  state is BUSY.
- mul_done  output  1  one-cycle strobe: mul_result and mul_rd are valid.
- mul_result  output  WIDTH  low WIDTH bits of A*B. Identical for signed and unsigned operands.
- mul_rd  output  5  destination register of the completed multiply.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; acc, mcand, mplier, cnt, rd_q cleared.
  - Outputs: stall=0, busy=0, mul_done=0, mul_result=0, mul_rd=0.
  - Reset mid-multiply discards the operation; no mul_done follows.
- start = dx_valid && (ALUctr==MUL_OP) && !flush.
- States:
  - IDLE: on start, latch mcand=A, mplier=B, acc=0, cnt=0, rd_q=DX_RD, then go to BUSY. Otherwise stay.
  - BUSY, each cycle:
    - if mplier[0], acc += mcand (mod 2^WIDTH);
    - mcand <<= 1; mplier >>= 1; cnt++.
    - Go to DONE when cnt==WIDTH-1, or when EARLY_EXIT and the post-shift mplier==0.
  - DONE: mul_done=1, mul_result=acc, mul_rd=rd_q.
    - If start, relatch operands and go to BUSY (back-to-back multiply, no idle cycle).
    - Else go to IDLE.
- stall (combinational) = (state==BUSY) || (start && state!=BUSY). stall is high in the issue cycle so DX holds the mul instruction.
- mul_result and mul_rd are zero whenever mul_done=0.
- Latency, start seen at cycle T:
  - EARLY_EXIT=0: BUSY T+1..T+WIDTH, DONE at T+WIDTH+1; stall high T..T+WIDTH.
  - EARLY_EXIT=1: BUSY cycles = max(1, index of highest set bit of B + 1); B=0 gives exactly 1 BUSY cycle.
- flush:
  - In BUSY or DONE: next state IDLE, no mul_done.
  - flush in the same cycle as a would-be start blocks the start.
- Non-mul ALUctr or dx_valid=0 in IDLE: no effect, stall=0.
- Operand changes while BUSY are ignored (operands are latched).
- Overflow beyond WIDTH bits is discarded silently.

Decomposition:
- Shared package holds:
  - ALUctr encodings (ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5, BRANCH=6);
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One sub-module, mul_shift_add_step: combinational single iteration (acc, mcand, mplier in; next acc, mcand, mplier, zero_flag out).
- The FSM, counter and stall logic stay in ex_mul_sequencer.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start asserted -> stall=0, busy=0, mul_done=0, mul_result=0 throughout.
- EARLY_EXIT=0, A=7, B=6 at T -> stall high T..T+32; mul_done only at T+33 with mul_result=42, mul_rd=DX_RD.
- EARLY_EXIT=1, A=32'hFFFF_FFFF, B=3 -> 2 BUSY cycles; mul_done at T+3 with mul_result=32'hFFFF_FFFD. Also B=0 -> mul_done at T+2, result 0.
- Back-to-back: second mul (A=5, B=5, RD=9) presented in the first mul's DONE cycle -> first result 42 emitted, second result 25 with mul_rd=9 follows, no IDLE gap.
- flush asserted at BUSY cycle 4 -> state IDLE next cycle, stall drops, no mul_done. Same test with rst=0 mid-BUSY -> identical abort.
- ALUctr=3'd0 with dx_valid=1, and ALUctr=5 with dx_valid=0 -> stall=0, busy=0, no mul_done.
